ibuf2axis: RTL and testbench
============================

Name: ibuf2axis

Overview:
- Transmit-side counterpart of the receive-path buffer writer.
- Reads packets that an upstream producer (host DMA engine) has written into a circular 64-bit-wide buffer (ibuf) and emits them on an AXI4-Stream master.
- Packet format in the buffer: one header word, then ceil(len/8) data words.
- Tracks the producer's committed pointer and returns a consumer pointer once each packet has been fully transmitted.

Parameters:
- BW, 10: buffer address width; the buffer holds 2**BW words, and pointers are BW+1 bits.
- SRC_PORT, 8'h00: port tag driven on m_axis_tuser[23:16].
- MAX_LEN, 16'd1518: largest legal packet length in bytes.

Ports:
- m_axis_aclk  in  1  clock
- m_axis_aresetp  in  1  reset; one clock; reset is synchronous and active-high
- m_axis_tdata  out  64  stream data; byte 0 is in [7:0]
- m_axis_tstrb  out  8  byte enables
- m_axis_tuser  out  128  sideband: [15:0] length, [23:16] SRC_PORT, [31:24] destination port, rest 0
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  last beat of packet
- m_axis_tready  in  1  sink ready
- committed_prod  in  BW+1  producer pointer: words written and committed
- committed_cons  out  BW+1  consumer pointer: words fully transmitted
- rd_addr  out  BW-1:0  buffer read address
- rd_data  in  64  buffer read data; valid exactly 1 cycle after rd_addr
- err  out  1  sticky: illegal header seen

Behaviour:
- Reset values (synchronous, active-high):
  - tvalid=0, tlast=0, tdata=0, tstrb=0, tuser=0.
  - committed_cons=0, internal rd_ptr=0, rd_addr=0, err=0.
  - FSM goes to IDLE.
  - Reset mid-packet abandons the packet with no tlast; the producer is reset together with this block.
- Pointer arithmetic:
  - avail = committed_prod - rd_ptr, modulo 2**(BW+1).
  - rd_addr = pointer[BW-1:0], so the address wraps naturally.
  - The full buffer (avail == 2**BW) is a legal state.
- Header word layout:
  - [47:32] len in bytes.
  - [55:48] destination port.
  - All other bits ignored.
  - nwords = ceil(len/8) = (len+7)>>3.
- FSM:
  - IDLE:
    - Hold while avail==0.
    - Otherwise drive rd_addr=rd_ptr[BW-1:0] and go to HDR.
  - HDR:
    - Latch len, destination port and nwords from rd_data.
    - len==0: rd_ptr+=1, committed_cons=rd_ptr+1, go to IDLE, no output.
    - len>MAX_LEN: err<=1, go to HALT.
    - Otherwise rd_ptr+=1 and go to WAIT.
  - WAIT:
    - Hold until avail >= nwords, so the whole packet is committed before streaming starts.
    - Then start reads and go to STREAM.
  - STREAM:
    - One beat per cycle sustained while tready=1.
    - Use a 2-entry skid/prefetch buffer to absorb the 1-cycle read latency.
    - tuser holds the same value on every beat: {96'b0, dst, SRC_PORT, len}.
    - tstrb=8'hFF on every beat except the last.
    - Last beat: tstrb = (len[2:0]==0) ? 8'hFF : (8'h01<<len[2:0])-1.
    - tlast=1 only on beat nwords.
  - On the tlast handshake (tvalid & tready & tlast):
    - committed_cons <= packet start pointer + 1 + nwords, i.e. header included.
    - Go to IDLE.
  - HALT: tvalid=0 and committed_cons frozen until reset.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata/tstrb/tuser/tlast are held stable.
  - tvalid never deasserts inside a packet before tlast is accepted.
  - tvalid is not gated by tready.
- Latency:
  - From the cycle committed_prod covers header plus all data, with the FSM in IDLE and the header not yet read, first tvalid rises in ≤4 cycles.
  - After the tlast handshake, the next packet's first tvalid rises in ≤4 cycles if that packet is already committed.
- committed_cons only ever advances at packet granularity; it never points mid-packet.
- committed_prod changing while streaming is legal; it only affects later packets.

Test Plan:
- Single packet, len=64 at address 0 (header + 8 words), committed_prod 0→9, tready=1 → 8 beats, tstrb=FF on all, tlast on beat 8, tuser[15:0]=64; tvalid ≤4 cycles after the commit; committed_cons=9 the cycle after tlast.
- len=61 (8 words) → beat 8 tstrb=8'h1F; len=1 → one beat, tstrb=8'h01, tlast=1.
- Random tready at 50% over 100 packets with random len 1..1518 → byte stream and tuser match the model; outputs stable during stalls; no tvalid gap mid-packet.
- Wrap: BW=4, rd_ptr starting at 14, packet of 5 words → rd_addr sequence 14,15,0,1,2; committed_cons=19 (mod 32); data order correct.
- Header committed but data only partially committed (prod = start+3 for nwords=4) → tvalid stays 0; bump prod by 2 → packet streams.
- len=0 header → no beats, committed_cons+=1. len=2000 → err=1, tvalid stays 0. Then assert reset mid-stream → all outputs return to reset values on the next edge, and the stream restarts cleanly from pointer 0.

Source files
------------

// File: rtl/ibuf2axis_if.sv
// rtl/ibuf2axis_if.sv - AXI4-Stream bundle carrying ibuf packets to the sink
interface ibuf2axis_if;
    logic [63:0]  tdata;
    logic [7:0]   tstrb;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ibuf2axis.sv
// rtl/ibuf2axis.sv - reads header+data packets from a circular ibuf and streams them out
module ibuf2axis #(
    parameter int          BW       = 10,
    parameter logic [7:0]  SRC_PORT = 8'h00,
    parameter logic [15:0] MAX_LEN  = 16'd1518
) (
    input  logic          m_axis_aclk,
    input  logic          m_axis_aresetp,
    ibuf2axis_if.master   m_axis,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic          err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [BW:0]  rd_ptr_q, rd_ptr_d;
    logic [BW:0]  fetch_q, fetch_d;
    logic [BW:0]  cons_q, cons_d;
    logic         err_q, err_d;
    logic [15:0]  len_q, len_d;
    logic [7:0]   dst_q, dst_d;
    logic [13:0]  nwords_q, nwords_d;
    logic [13:0]  issued_q, issued_d;
    logic [13:0]  loaded_q, loaded_d;
    logic         pend_q, pend_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [63:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic         tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [63:0]  tdata_q, tdata_d;
    logic [7:0]   tstrb_q, tstrb_d;
    logic [127:0] tuser_q, tuser_d;

    logic [BW:0]  avail;
    logic [16:0]  hdr_sum;
    logic [15:0]  hdr_len;
    logic [7:0]   last_strb;
    logic         out_fire, src_buf, load, pop, push, issue;
    logic [1:0]   cnt_next, widx;

    assign avail     = committed_prod - rd_ptr_q;
    assign hdr_len   = rd_data[47:32];
    assign hdr_sum   = {1'b0, hdr_len} + 17'd7;
    assign last_strb = (len_q[2:0] == 3'd0) ? 8'hFF : ((8'h01 << len_q[2:0]) - 8'h01);
    assign out_fire  = tvalid_q & m_axis.tready;

    // The read address is the fetch pointer itself, so rd_data always answers the
    // read issued in the previous cycle.
    assign rd_addr        = fetch_q[BW-1:0];
    assign committed_cons = cons_q;
    assign err            = err_q;
    assign m_axis.tdata   = tdata_q;
    assign m_axis.tstrb   = tstrb_q;
    assign m_axis.tuser   = tuser_q;
    assign m_axis.tvalid  = tvalid_q;
    assign m_axis.tlast   = tlast_q;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        fetch_d  = fetch_q;
        cons_d   = cons_q;
        err_d    = err_q;
        len_d    = len_q;
        dst_d    = dst_q;
        nwords_d = nwords_q;
        issued_d = issued_q;
        loaded_d = loaded_q;
        pend_d   = 1'b0;
        cnt_d    = cnt_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        src_buf  = (cnt_q != 2'd0);
        load     = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        issue    = 1'b0;
        cnt_next = cnt_q;
        widx     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (avail != '0) begin
                    fetch_d = rd_ptr_q + 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                len_d    = hdr_len;
                dst_d    = rd_data[55:48];
                nwords_d = hdr_sum[16:3];
                issued_d = '0;
                loaded_d = '0;
                if (hdr_len == 16'd0) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    cons_d   = rd_ptr_q + 1'b1;
                    state_d  = S_IDLE;
                end else if (hdr_len > MAX_LEN) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (32'(avail) >= 32'(nwords_q)) begin
                    fetch_d  = fetch_q + 1'b1;
                    pend_d   = 1'b1;
                    issued_d = 14'd1;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                // Output register first, then the 2-deep skid buffer, then the RAM port.
                load     = (!tvalid_q || out_fire) && (src_buf || pend_q);
                pop      = load && src_buf;
                push     = pend_q && !(load && !src_buf);
                widx     = cnt_q - {1'b0, pop};
                cnt_next = cnt_q + {1'b0, pend_q} - {1'b0, load};
                cnt_d    = cnt_q - {1'b0, pop} + {1'b0, push};
                if (pop)
                    buf0_d = buf1_q;
                if (push) begin
                    if (widx == 2'd0)
                        buf0_d = rd_data;
                    else
                        buf1_d = rd_data;
                end
                issue = (issued_q != nwords_q) && (cnt_next <= 2'd1);
                if (issue) begin
                    pend_d   = 1'b1;
                    fetch_d  = fetch_q + 1'b1;
                    issued_d = issued_q + 14'd1;
                end
                if (load) begin
                    tvalid_d = 1'b1;
                    tdata_d  = src_buf ? buf0_q : rd_data;
                    tlast_d  = (loaded_q + 14'd1 == nwords_q);
                    tstrb_d  = (loaded_q + 14'd1 == nwords_q) ? last_strb : 8'hFF;
                    tuser_d  = {96'b0, dst_q, SRC_PORT, len_q};
                    loaded_d = loaded_q + 14'd1;
                end else if (out_fire) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
                if (out_fire && tlast_q) begin
                    rd_ptr_d = rd_ptr_q + (BW+1)'(nwords_q);
                    fetch_d  = rd_ptr_q + (BW+1)'(nwords_q);
                    cons_d   = rd_ptr_q + (BW+1)'(nwords_q);
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_HALT: begin
                tvalid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_aresetp) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            fetch_q  <= '0;
            cons_q   <= '0;
            err_q    <= 1'b0;
            len_q    <= '0;
            dst_q    <= '0;
            nwords_q <= '0;
            issued_q <= '0;
            loaded_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            fetch_q  <= fetch_d;
            cons_q   <= cons_d;
            err_q    <= err_d;
            len_q    <= len_d;
            dst_q    <= dst_d;
            nwords_q <= nwords_d;
            issued_q <= issued_d;
            loaded_q <= loaded_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
        end
    end
endmodule

// File: tb/tb_ibuf2axis.sv
// tb/tb_ibuf2axis.sv - scoreboard bench for ibuf2axis (BW=10 main instance, BW=4 wrap instance)
module tb_ibuf2axis;
    localparam int         BW  = 10;
    localparam logic [7:0] SRC = 8'hA5;
    localparam logic [7:0] SRC4 = 8'h4B;

    typedef struct packed {
        logic [63:0]  d;
        logic [7:0]   s;
        logic         l;
        logic [127:0] u;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rst4, tready, rand_rdy, done4, logging;
    logic [BW:0]   prod, wp;
    wire  [BW:0]   cons;
    wire  [BW-1:0] rd_addr;
    logic [63:0]   rd_data;
    wire           err;
    logic [63:0]   mem [0:1023];

    logic [4:0]    prod4, wp4;
    wire  [4:0]    cons4;
    wire  [3:0]    rd_addr4;
    logic [63:0]   rd_data4;
    wire           err4;
    logic [63:0]   mem4 [0:15];

    beat_t q[$];
    beat_t q4[$];
    logic [3:0] alog[$];
    int checks = 0;
    int errors = 0;

    ibuf2axis_if axis();
    ibuf2axis_if axis4();
    assign axis.tready  = tready;
    assign axis4.tready = 1'b1;

    ibuf2axis #(.BW(BW), .SRC_PORT(SRC), .MAX_LEN(16'd1518)) dut (
        .m_axis_aclk(clk), .m_axis_aresetp(rst), .m_axis(axis),
        .committed_prod(prod), .committed_cons(cons),
        .rd_addr(rd_addr), .rd_data(rd_data), .err(err));

    ibuf2axis #(.BW(4), .SRC_PORT(SRC4), .MAX_LEN(16'd1518)) dut4 (
        .m_axis_aclk(clk), .m_axis_aresetp(rst4), .m_axis(axis4),
        .committed_prod(prod4), .committed_cons(cons4),
        .rd_addr(rd_addr4), .rd_data(rd_data4), .err(err4));

    always @(posedge clk) rd_data  <= mem[rd_addr];
    always @(posedge clk) rd_data4 <= mem4[rd_addr4];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input int pid, input int i);
        logic [31:0] h;
        h = 32'h9E3779B9 * 32'(pid * 1000 + i + 1);
        return {16'(pid), 16'(i), h};
    endfunction

    function automatic logic [7:0] strb_of(input int len);
        logic [7:0] s;
        int r;
        r = len % 8;
        for (int b = 0; b < 8; b++) s[b] = (r == 0) || (b < r);
        return s;
    endfunction

    task automatic put_pkt(input int pid, input int len, input logic [7:0] dst,
                           input logic [7:0] lstrb, input bit push_exp);
        int nw;
        beat_t b;
        nw = (len + 7) / 8;
        mem[wp[BW-1:0]] = {8'h5A, dst, 16'(len), 32'h0BADF00D};
        wp = wp + 1'b1;
        for (int i = 0; i < nw; i++) begin
            mem[wp[BW-1:0]] = word(pid, i);
            wp = wp + 1'b1;
            b.d = word(pid, i);
            b.s = (i == nw - 1) ? lstrb : 8'hFF;
            b.l = (i == nw - 1);
            b.u = {96'b0, dst, SRC, 16'(len)};
            if (push_exp) q.push_back(b);
        end
    endtask

    task automatic wait_cons(input logic [BW:0] exp, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (cons == exp) break;
        end
        chk(nm, cons, exp);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_tvalid"}, axis.tvalid, 1'b0);
        chk({pfx, "_tlast"},  axis.tlast, 1'b0);
        chk({pfx, "_tdata"},  axis.tdata, 64'h0);
        chk({pfx, "_tstrb"},  axis.tstrb, 8'h0);
        chk({pfx, "_tuser"},  axis.tuser, 128'h0);
        chk({pfx, "_cons"},   cons, 11'h0);
        chk({pfx, "_rd_addr"}, rd_addr, 10'h0);
        chk({pfx, "_err"},    err, 1'b0);
    endtask

    // Main-instance monitor: scoreboard pop, stall stability, no tvalid gaps.
    initial begin
        beat_t cur, prev;
        logic in_pkt, prev_stall;
        in_pkt = 0; prev_stall = 0; prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pkt = 0; prev_stall = 0;
            end else begin
                cur.d = axis.tdata; cur.s = axis.tstrb; cur.l = axis.tlast; cur.u = axis.tuser;
                if (prev_stall) chk("stall_hold", {axis.tvalid, cur}, {1'b1, prev});
                if (in_pkt) chk("tvalid_gap", axis.tvalid, 1'b1);
                if (axis.tvalid && tready) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", cur);
                    end else begin
                        chk("beat", cur, q.pop_front());
                    end
                end
                if (axis.tvalid) in_pkt = !(tready && axis.tlast);
                prev_stall = axis.tvalid && !tready;
                prev = cur;
            end
        end
    end

    initial begin
        beat_t cur;
        forever begin
            @(negedge clk);
            if (!rst4 && axis4.tvalid) begin
                cur.d = axis4.tdata; cur.s = axis4.tstrb; cur.l = axis4.tlast; cur.u = axis4.tuser;
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat4 actual=%0h required=none", cur);
                end else begin
                    chk("beat4", cur, q4.pop_front());
                end
            end
            if (logging && alog.size() > 0 && rd_addr4 != alog[$]) alog.push_back(rd_addr4);
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Wrap test on the BW=4 instance: 14-word packet, then a 5-word packet at 14.
    initial begin
        beat_t b;
        localparam int exp_addr [5] = '{14, 15, 0, 1, 2};
        logic [7:0] a;
        done4 = 0; logging = 0; rst4 = 1; prod4 = '0; wp4 = '0;
        for (int i = 0; i < 16; i++) mem4[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst4 = 0;
        for (int p = 0; p < 2; p++) begin
            int len, nw;
            len = (p == 0) ? 104 : 29;
            nw = (len + 7) / 8;
            mem4[wp4[3:0]] = {8'h00, 8'h21 + 8'(p), 16'(len), 32'h0};
            wp4 = wp4 + 1'b1;
            for (int i = 0; i < nw; i++) begin
                mem4[wp4[3:0]] = word(50 + p, i);
                wp4 = wp4 + 1'b1;
                b.d = word(50 + p, i);
                b.s = (i == nw - 1) ? ((p == 0) ? 8'hFF : 8'h1F) : 8'hFF;
                b.l = (i == nw - 1);
                b.u = {96'b0, 8'h21 + 8'(p), SRC4, 16'(len)};
                q4.push_back(b);
            end
            if (p == 1) begin
                alog.push_back(rd_addr4);
                logging = 1;
            end
            prod4 = wp4;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (cons4 == wp4) break;
            end
            chk(p == 0 ? "wrap_cons_first" : "wrap_cons", cons4, (p == 0) ? 5'd14 : 5'd19);
        end
        logging = 0;
        for (int i = 0; i < 5; i++) begin
            a = (i < alog.size()) ? {4'h0, alog[i]} : 8'hFF;
            chk("wrap_rd_addr", a, 8'(exp_addr[i]));
        end
        chk("wrap_q_empty", q4.size(), 0);
        done4 = 1;
    end

    initial begin
        int k;
        logic found, seen;
        logic [BW:0] s, used;
        rst = 1; prod = '0; wp = '0; rand_rdy = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 0;

        // len=64 at address 0, latency and consumer pointer timing
        put_pkt(1, 64, 8'h3C, 8'hFF, 1);
        prod = wp;
        k = 0;
        while (!axis.tvalid && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k > 4) begin
            errors++;
            $display("FAIL first_tvalid_latency actual=%0d required<=4", k);
        end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = axis.tvalid && tready && axis.tlast;
        end
        @(posedge clk); #1;
        chk("tlast_seen", found, 1'b1);
        chk("cons_after_tlast", cons, 11'd9);

        // len=61 then len=1, back to back
        put_pkt(2, 61, 8'h01, 8'h1F, 1);
        put_pkt(3, 1, 8'h02, 8'h01, 1);
        prod = wp;
        wait_cons(11'd20, 200, "cons_61_1");

        // 100 random packets with 50% tready
        rand_rdy = 1;
        for (int p = 0; p < 100; p++) begin
            int len, nw, t;
            len = $urandom_range(1, 1518);
            nw = (len + 7) / 8;
            t = 0;
            used = wp - cons;
            while (int'(used) + 1 + nw > 1024 && t < 5000) begin
                @(posedge clk); #1;
                used = wp - cons;
                t++;
            end
            if (t >= 5000) begin
                checks++; errors++;
                $display("FAIL space_timeout actual=%0d required<=%0d", int'(used) + 1 + nw, 1024);
            end
            put_pkt(100 + p, len, 8'($urandom), strb_of(len), 1);
            prod = wp;
        end
        wait_cons(wp, 40000, "random_cons");
        rand_rdy = 0;
        chk("random_q_empty", q.size(), 0);

        // header committed but data only partly committed
        s = wp;
        put_pkt(5, 32, 8'h07, 8'hFF, 1);
        prod = s + 11'd3;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | axis.tvalid;
        end
        chk("partial_no_tvalid", seen, 1'b0);
        prod = s + 11'd5;
        wait_cons(s + 11'd5, 100, "partial_done");

        // zero-length header is consumed silently
        s = wp;
        put_pkt(6, 0, 8'h09, 8'hFF, 1);
        prod = wp;
        wait_cons(s + 11'd1, 50, "len0_cons");
        chk("len0_no_beats", q.size(), 0);

        // oversize header halts with err
        s = wp;
        put_pkt(7, 2000, 8'h0A, 8'hFF, 0);
        prod = s + 11'd1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | axis.tvalid;
        end
        chk("halt_err", err, 1'b1);
        chk("halt_no_tvalid", seen, 1'b0);
        chk("halt_cons_frozen", cons, s);

        // reset out of HALT, then reset mid-stream
        @(posedge clk); #1;
        rst = 1; prod = '0;
        @(posedge clk); #1;
        rst = 0; q.delete(); wp = '0;
        put_pkt(8, 80, 8'h0B, 8'hFF, 1);
        prod = wp;
        k = 0;
        while (!axis.tvalid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("midstream_active", axis.tvalid, 1'b1);
        rst = 1; prod = '0;
        @(posedge clk); #1;
        chk_reset_vals("midreset");
        rst = 0; q.delete(); wp = '0;
        put_pkt(9, 24, 8'h0C, 8'hFF, 1);
        prod = wp;
        wait_cons(11'd4, 50, "restart_cons");
        chk("restart_q_empty", q.size(), 0);

        k = 0;
        while (!done4 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        chk("wrap_done", done4, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
